// File: rtl/dbg_host_port_if.sv
// Host-side command, write-beat and read-word handshakes of the debug port master.
interface dbg_host_port_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [31:0]      wdata;
    logic             rdata_valid;
    logic             rdata_ready;
    logic [31:0]      rdata;
    logic             done;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
        output cmd_ready, wdata_ready, rdata_valid, rdata, done, busy
    );
endinterface

// File: rtl/dbg_host_port.sv
// Debug/load port master: turns host bursts into timed CPU cmd/addr/data cycles,
// with address auto-increment and D-cache read-latency alignment.
module dbg_host_port #(
    parameter int LEN_W    = 8,
    parameter int READ_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    dbg_host_port_if.slave host,
    output logic [1:0]     cpu_cmd,
    output logic [31:0]    cpu_addr,
    output logic [31:0]    cpu_wdata,
    input  logic [31:0]    cpu_rdata
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RD_RESP, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op;
    logic [31:0]      addr;
    logic [LEN_W-1:0] remaining;
    logic             iss_vld_p1;
    logic [31:0]      iss_addr_p1;
    logic [31:0]      iss_data_p1;
    logic [31:0]      rdata_q;
    logic [LAT_W-1:0] lat_cnt;
    logic             cmd_acc, beat_acc, resp_acc, lat_last, capture;

    assign cmd_acc  = (state == IDLE) && host.cmd_valid;
    assign beat_acc = (state == WRITE) && host.wdata_valid && (remaining != '0);
    assign resp_acc = (state == RD_RESP) && host.rdata_ready;
    assign lat_last = (lat_cnt == LAT_W'(READ_LAT - 1));
    assign capture  = ((state == RD_ADDR) && !op[1]) || ((state == RD_WAIT) && lat_last);
    assign host.rdata = rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // The write op codes (01/11) and D-cache read code (10) equal cpu_cmd directly.
    always_comb begin
        state_nxt        = state;
        host.cmd_ready   = 1'b0;
        host.wdata_ready = 1'b0;
        host.rdata_valid = 1'b0;
        host.done        = 1'b0;
        host.busy        = 1'b1;
        cpu_cmd          = iss_vld_p1 ? op : 2'b00;
        cpu_addr         = iss_addr_p1;
        cpu_wdata        = iss_data_p1;
        case (state)
            IDLE: begin
                host.cmd_ready = 1'b1;
                host.busy      = 1'b0;
                if (host.cmd_valid) state_nxt = host.cmd_op[0] ? WRITE : RD_ADDR;
            end
            WRITE: begin
                host.wdata_ready = (remaining != '0);
                if ((remaining == '0) && iss_vld_p1) state_nxt = DONE;
            end
            RD_ADDR: begin
                cpu_cmd   = op;
                cpu_addr  = addr;
                state_nxt = op[1] ? RD_WAIT : RD_RESP;
            end
            RD_WAIT: begin
                cpu_cmd  = op;
                cpu_addr = addr;
                if (lat_last) state_nxt = RD_RESP;
            end
            RD_RESP: begin
                host.rdata_valid = 1'b1;
                if (host.rdata_ready) state_nxt = (remaining == LEN_W'(1)) ? DONE : RD_ADDR;
            end
            DONE: begin
                host.done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: an accepted write beat is issued to the CPU on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op          <= 2'b00;
            addr        <= '0;
            remaining   <= '0;
            iss_vld_p1  <= 1'b0;
            iss_addr_p1 <= '0;
            iss_data_p1 <= '0;
            rdata_q     <= '0;
            lat_cnt     <= '0;
        end else begin
            iss_vld_p1 <= beat_acc;
            if (cmd_acc) begin
                op        <= host.cmd_op;
                addr      <= host.cmd_addr;
                remaining <= (host.cmd_len == '0) ? LEN_W'(1) : host.cmd_len;
            end
            if (beat_acc) begin
                iss_addr_p1 <= addr;
                iss_data_p1 <= host.wdata;
                addr        <= addr + 32'd4;
                remaining   <= remaining - LEN_W'(1);
            end
            if (state == RD_WAIT) lat_cnt <= lat_last ? '0 : lat_cnt + LAT_W'(1);
            else                  lat_cnt <= '0;
            if (capture) rdata_q <= cpu_rdata;
            if (resp_acc) begin
                addr      <= addr + (op[1] ? 32'd4 : 32'd1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: doc/dbg_host_port.md
Name: dbg_host_port

Overview:
- Host-side master for the CPU external debug/load port: cmd, addr_in, data_in and data_out.
- Turns a simple host command stream into correctly timed port cycles:
  - burst program load into I-cache;
  - burst data load into D-cache;
  - burst readback of the register file or D-cache.
- Sits between a host link (UART or JTAG bridge) and the CPU's external pins.
- Provides the write/read sequencing, address auto-increment and D-cache read-latency alignment that the CPU port does not.

Parameters:
- LEN_W, 8: width of burst length field.
- READ_LAT, 1: cycles from cpu_addr valid to D-cache data valid on cpu_rdata (synchronous port-B BRAM).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  block can accept a command (IDLE only).
- cmd_op  input  2  0 = reg read, 1 = I-cache write, 2 = D-cache read, 3 = D-cache write.
- cmd_addr  input  32  start address (byte address for memories, register index for reg read).
- cmd_len  input  LEN_W  number of words; 0 is treated as 1.
- wdata_valid  input  1  write beat valid.
- wdata_ready  output  1  write beat accepted.
- wdata  input  32  write beat data.
- rdata_valid  output  1  read word valid.
- rdata_ready  input  1  host accepts read word.
- rdata  output  32  read word.
- done  output  1  one-cycle pulse when a burst completes.
- busy  output  1  high whenever state is not IDLE.
- cpu_cmd  output  2  drives CPU cmd.
- cpu_addr  output  32  drives CPU addr_in.
- cpu_wdata  output  32  drives CPU data_in.
- cpu_rdata  input  32  from CPU data_out.

Behaviour:
- Reset (reset=0, async): state IDLE; cpu_cmd=2'b00 (reg read, no write side effect); cpu_addr=0, cpu_wdata=0, rdata=0; rdata_valid=0, done=0, busy=0, wdata_ready=0; cmd_ready=1 after release.
- Reset mid-burst: aborts immediately. A write beat accepted but not yet issued is dropped; no write cmd reaches the CPU after reset asserts.
- Idle encoding: cpu_cmd=00 in every cycle not issuing a write or D-cache read.
- Command capture: cmd_valid&&cmd_ready latches op, addr, and remaining = max(len,1).
  - op 1 or 3 -> WRITE.
  - op 0 or 2 -> RD_ADDR.
- WRITE state:
  - wdata_ready = (remaining != 0).
  - Beat accepted in cycle N -> in cycle N+1: cpu_cmd = 01 (op 1) or 11 (op 3) for exactly one cycle, cpu_addr = current addr, cpu_wdata = beat.
  - One beat per cycle is sustainable; back-to-back beats give consecutive write cycles.
  - addr += 4 and remaining -= 1 per accepted beat.
  - After the last beat's issue cycle: done pulse, then IDLE.
  - wdata_valid low inserts idle (00) cycles; no timeout.
- RD_ADDR: drive cpu_addr = addr and cpu_cmd = 00 (reg) or 10 (D-cache).
  - Reg read: capture cpu_rdata at the end of this cycle (combinational path).
  - D-cache read: hold address and cmd for READ_LAT cycles in RD_WAIT, then capture.
- RD_RESP: rdata_valid=1 with the captured word, held stable until rdata_ready.
  - On handshake: addr += 1 for reg reads, += 4 for D-cache; remaining -= 1.
  - remaining != 0 -> RD_ADDR; remaining = 0 -> done pulse, IDLE.
- Read throughput: one word per 2 (reg) or 2+READ_LAT (D-cache) cycles minimum.
- Arithmetic: addr increments are modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000). A reg index of 31 followed by +1 rolls addr[4:0] to 0.
- cmd_valid while busy is ignored (cmd_ready=0). wdata_valid outside WRITE is ignored (wdata_ready=0).
- done and cmd_ready: done is never asserted in the same cycle as cmd_ready. IDLE is entered the cycle after done.

Test Plan:
- Reset mid-transfer: I-cache write len=4, reset asserted after beat 2 accepted -> at most 2 cpu_cmd=01 cycles observed, cpu_cmd=00 while reset low and after release, busy=0.
- I-cache load: op1, addr 0x0, len 3, beats 0x00500093/0x00100113/0x002081B3 back-to-back -> three consecutive cpu_cmd=01 cycles at addr 0x0/0x4/0x8 with matching cpu_wdata, one done pulse.
- D-cache write then read: op3 addr 0x40 len 2 (0xDEADBEEF, 0x12345678), then op2 addr 0x40 len 2 against a BRAM model with READ_LAT=1 -> rdata 0xDEADBEEF then 0x12345678.
- Reg read with backpressure: op0 addr 30 len 3, rdata_ready held low 5 cycles per word -> rdata stable while waiting; indices 30, 31, 0 read.
- Edge lengths/wrap: op3 addr 0xFFFFFFFC len 0 -> exactly one write at 0xFFFFFFFC. Then len 2 from the same address -> second write at 0x00000000.
- Stalled beats: op1 len 2 with wdata_valid gapped 3 cycles -> cpu_cmd=00 during gap, no spurious write, done only after the second issue.
